// File: rtl/float_word_serializer_if.sv
// Handshake and serial-output bundle for float_word_serializer.
// The master side feeds words and watches the serial frame; the slave is the serializer.
interface float_word_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_balance;
    logic        ser_out;
    logic        ser_valid;
    logic        frame_start;
    logic        frame_end;
    logic        busy;
    logic        parity_err;
    logic [7:0]  frames_sent;

    modport master (
        output in_valid, in_word, in_balance,
        input  in_ready, ser_out, ser_valid, frame_start, frame_end,
               busy, parity_err, frames_sent
    );

    modport slave (
        input  in_valid, in_word, in_balance,
        output in_ready, ser_out, ser_valid, frame_start, frame_end,
               busy, parity_err, frames_sent
    );
endinterface

// File: rtl/float_word_serializer.sv
// float_word_serializer: captures a 32-bit float word plus its balance bit and
// shifts them out as a 33-bit frame (word MSB first, balance bit last), then
// idles GAP_CYCLES cycles before accepting the next word.
// Optional macro FLOAT_SER_PARITY_CHECK_EN: checks the balance bit at capture
// and drops mismatching words through a one-cycle REJ state with parity_err.
// Every output is a register loaded from the next-state values.
module float_word_serializer #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    float_word_serializer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PAR,
        GAP
`ifdef FLOAT_SER_PARITY_CHECK_EN
        , REJ
`endif
    } state_t;

    // GAP counts down from GAP_CYCLES-1 to 0, one cycle per count.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t      state, nxt;
    logic [31:0] sr, sr_nxt;
    logic        bal_q, bal_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [3:0]  gcnt, gcnt_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        perr_nxt;
    logic        sval_nxt, sout_nxt, fstart_nxt, fend_nxt;

    // Next-state, datapath and next-output decode.
    always_comb begin
        nxt      = state;
        sr_nxt   = sr;
        bal_nxt  = bal_q;
        idx_nxt  = idx;
        gcnt_nxt = gcnt;
        cnt_nxt  = cnt;
        perr_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_nxt  = bus.in_word;
                    bal_nxt = bus.in_balance;
                    idx_nxt = 5'd31;
                    nxt     = SHIFT;
`ifdef FLOAT_SER_PARITY_CHECK_EN
                    // Balance bit must be 1 exactly when the ones-count is even.
                    if (bus.in_balance != ~^bus.in_word) begin
                        nxt      = REJ;
                        perr_nxt = 1'b1;
                    end
`endif
                end
            end
            SHIFT: begin
                if (idx == 5'd0) begin
                    nxt     = PAR;
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    idx_nxt = idx - 5'd1;
                end
            end
            PAR: begin
                idx_nxt = 5'd31;
                if (GAP_CYCLES > 0) begin
                    nxt      = GAP;
                    gcnt_nxt = GAP_LOAD;
                end else begin
                    nxt = IDLE;
                end
            end
            GAP: begin
                if (gcnt == 4'd0) nxt = IDLE;
                else              gcnt_nxt = gcnt - 4'd1;
            end
`ifdef FLOAT_SER_PARITY_CHECK_EN
            REJ: nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase

        sval_nxt   = (nxt == SHIFT) || (nxt == PAR);
        sout_nxt   = 1'b0;
        if (nxt == SHIFT)    sout_nxt = sr_nxt[idx_nxt];
        else if (nxt == PAR) sout_nxt = bal_nxt;
        fstart_nxt = (nxt == SHIFT) && (idx_nxt == 5'd31);
        fend_nxt   = (nxt == PAR);
    end

    // State, datapath and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            sr              <= '0;
            bal_q           <= 1'b0;
            idx             <= 5'd31;
            gcnt            <= 4'd0;
            cnt             <= 8'd0;
            bus.in_ready    <= 1'b1;
            bus.ser_out     <= 1'b0;
            bus.ser_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frames_sent <= 8'd0;
        end else begin
            state           <= nxt;
            sr              <= sr_nxt;
            bal_q           <= bal_nxt;
            idx             <= idx_nxt;
            gcnt            <= gcnt_nxt;
            cnt             <= cnt_nxt;
            bus.in_ready    <= (nxt == IDLE);
            bus.ser_out     <= sout_nxt;
            bus.ser_valid   <= sval_nxt;
            bus.frame_start <= fstart_nxt;
            bus.frame_end   <= fend_nxt;
            bus.busy        <= (nxt != IDLE);
            bus.parity_err  <= perr_nxt;
            bus.frames_sent <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_float_word_serializer.sv
// Scoreboard bench for float_word_serializer: the driver pushes expected frames
// (or expected rejections) when a handshake happens, and monitors compare what
// the serial port emits. A second instance with GAP_CYCLES=0 runs the
// back-to-back counter-wrap scenario.
module tb_float_word_serializer;

    localparam int G = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic rstz_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_word_serializer_if bus();
    float_word_serializer_if busz();

    float_word_serializer #(.GAP_CYCLES(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    float_word_serializer #(.GAP_CYCLES(0)) dutz (.clk(clk), .rst_n(rstz_n), .bus(busz));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: balance bit is 1 when the word has an even number of ones.
    function automatic bit even_ones(input logic [31:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    function automatic bit rejected(input logic [31:0] w, input logic b);
`ifdef FLOAT_SER_PARITY_CHECK_EN
        return b != even_ones(w);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard queues, written only by the driver.
    logic [32:0] exp_frame[$];
    int          exp_cyc[$];
    int          rej_q[$];

    // Driver bookkeeping for handshake spacing.
    int last_hs   = 0;
    bit last_held = 1'b0;
    bit last_rej  = 1'b0;

    task automatic send(input logic [31:0] w, input logic b, input bit hold);
        int budget;
        int hs;
        bit rej;
        @(negedge clk);
        bus.in_word    = w;
        bus.in_balance = b;
        bus.in_valid   = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            last_held = 1'b0;
            return;
        end
        hs = cyc + 1;
        @(posedge clk);
        rej = rejected(w, b);
        if (rej) rej_q.push_back(hs);
        else begin
            exp_frame.push_back({w, b});
            exp_cyc.push_back(hs);
        end
        if (last_held)
            check("handshake_spacing", hs - last_hs, last_rej ? 2 : 34 + G);
        last_hs   = hs;
        last_held = hold;
        last_rej  = rej;
        if (!hold) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Monitor state, written only by the main monitor.
    int          fr_ptr = 0;
    int          rej_ptr = 0;
    int          mcnt = 0;
    bit          cnt_chk = 1'b0;
    bit          collecting = 1'b0;
    int          nb = 0;
    int          start_cyc = 0;
    logic [32:0] got = '0;

    // Main monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check("rst_in_ready", bus.in_ready, 1);
            check("rst_outputs", {bus.ser_out, bus.ser_valid, bus.frame_start,
                                  bus.frame_end, bus.busy, bus.parity_err}, 0);
            check("rst_frames_sent", bus.frames_sent, 0);
            collecting = 1'b0;
            fr_ptr     = exp_frame.size();
            rej_ptr    = rej_q.size();
            mcnt       = 0;
            cnt_chk    = 1'b0;
        end else begin
            check("busy_vs_ready", bus.busy, !bus.in_ready);
            if (cnt_chk) begin
                check("frames_sent", bus.frames_sent, mcnt);
                cnt_chk = 1'b0;
            end
            if (bus.parity_err) begin
                if (rej_ptr < rej_q.size()) check("reject_cycle", cyc, rej_q[rej_ptr]);
                else                        check("unexpected_parity_err", 1, 0);
                check("reject_no_valid", bus.ser_valid, 0);
                rej_ptr++;
            end
            if (bus.ser_valid) begin
                if (bus.frame_start) begin
                    check("start_inside_frame", collecting, 0);
                    if (fr_ptr < exp_cyc.size()) check("start_cycle", cyc, exp_cyc[fr_ptr]);
                    else                         check("unexpected_frame", 1, 0);
                    collecting = 1'b1;
                    nb         = 0;
                    got        = '0;
                    start_cyc  = cyc;
                end else if (!collecting) begin
                    check("bit_outside_frame", 1, 0);
                end
                got = {got[31:0], bus.ser_out};
                nb++;
                if (bus.frame_end) begin
                    check("frame_len", nb, 33);
                    check("end_cycle", cyc - start_cyc, 32);
                    if (fr_ptr < exp_frame.size()) check("frame_data", got, exp_frame[fr_ptr]);
                    fr_ptr++;
                    mcnt       = (mcnt + 1) % 256;
                    cnt_chk    = 1'b1;
                    collecting = 1'b0;
                end else if (nb >= 33) begin
                    check("missing_frame_end", nb, 32);
                    collecting = 1'b0;
                end
            end else begin
                check("idle_outputs", {bus.ser_out, bus.frame_start, bus.frame_end}, 0);
            end
        end
    end

    // GAP_CYCLES=0 instance: in_valid held high, frames must be 34 cycles apart.
    int zlast = -1;
    int zdone = 0;
    bit zchk  = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (rstz_n) begin
            if (zchk) begin
                check("z_frames_sent", busz.frames_sent, zdone % 256);
                zchk = 1'b0;
            end
            if (busz.ser_valid && busz.frame_start) begin
                if (zlast >= 0) check("z_spacing", cyc - zlast, 34);
                zlast = cyc;
            end
            if (busz.ser_valid && busz.frame_end) begin
                zdone++;
                zchk = 1'b1;
            end
        end
    end

    initial begin
        rstz_n           = 1'b0;
        busz.in_valid    = 1'b0;
        busz.in_word     = 32'h4049_0FDB;
        busz.in_balance  = even_ones(32'h4049_0FDB);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstz_n        = 1'b1;
        busz.in_valid = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] specials [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000};

    initial begin
        int budget;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_word    = '0;
        bus.in_balance = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0f: ones-count 7, balance 0.
        send(32'h3F80_0000, 1'b0, 1'b0);
        // Zero word then all-ones held back to back.
        send(32'h0000_0000, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        // Odd ones-count with balance 1: rejected only with the check enabled.
        send(32'h0000_0001, 1'b1, 1'b1);
        send(32'h4120_0000, even_ones(32'h4120_0000), 1'b0);

        foreach (specials[k]) send(specials[k], even_ones(specials[k]), k[0]);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] w;
            logic        b;
            w = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : even_ones(w);
            send(w, b, (i == 23) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a frame: abandoned, no frame_end, counter cleared.
        send(32'hC0A0_0000, even_ones(32'hC0A0_0000), 1'b0);
        while (cyc < last_hs + 9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        last_held = 1'b0;
        send(32'h3EAA_AAAB, even_ones(32'h3EAA_AAAB), 1'b0);

        budget = 0;
        while ((fr_ptr < exp_frame.size() || rej_ptr < rej_q.size() || bus.busy) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check("drain_frames", fr_ptr, exp_frame.size());
        check("drain_rejects", rej_ptr, rej_q.size());
        check("final_frames_sent", bus.frames_sent, mcnt);

        budget = 0;
        while (zdone < 257 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("z_wrap_done", zdone >= 257, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
